// File: rtl/spi_pkg.sv
// Shared types and default parameters for the SPI mode-0 master.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_t;

    localparam int SPI_DATA_W   = 8;
    localparam int SPI_HALF_DIV = 2;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer for the SPI master: tick every HALF_DIV cycles while running,
// qualified into SCLK rise/fall strobes.
module spi_clk_gen import spi_pkg::*; #(
    parameter int HALF_DIV = SPI_HALF_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic sclk,
    input  logic edge_en,
    output logic tick,
    output logic rise,
    output logic fall
);

    localparam int HC_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF_DIV - 1);

    logic [HC_W-1:0] hc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
        end else if (!run || tick) begin
            hc <= '0;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    assign tick = run && (hc == HC_LAST);
    assign rise = tick && edge_en && !sclk;
    assign fall = tick && edge_en && sclk;

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one DATA_W-bit MSB-first frame per start/ready handshake.
// Define SPI_MASTER_BURST_EN to chain back-to-back words under one chip-select window.
//
// state | meaning
// IDLE  | cs high, ready, waiting for start
// SETUP | cs low, MSB on MOSI, sclk low for one half-period
// SHIFT | 2*DATA_W sclk edges, then one trailing low half-period
// HOLD  | cs still low for one half-period after the last edge
// GAP   | cs high for one half-period before accepting again
module spi_master import spi_pkg::*; #(
    parameter int DATA_W   = SPI_DATA_W,
    parameter int HALF_DIV = SPI_HALF_DIV
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int EC_W = $clog2(2 * DATA_W + 1);
    localparam logic [EC_W-1:0] EC_LAST      = EC_W'(2 * DATA_W);
    localparam logic [EC_W-1:0] EC_FALL_LAST = EC_W'(2 * DATA_W - 1);

    spi_state_t        state;
    logic [EC_W-1:0]   ec;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic              run, edge_en, tick, rise, fall, hold_end, accept;

    assign run      = (state != IDLE);
    assign edge_en  = (state == SETUP) || ((state == SHIFT) && (ec != EC_LAST));
    assign hold_end = (state == HOLD) && tick;

`ifdef SPI_MASTER_BURST_EN
    assign ready = (state == IDLE) || hold_end;
`else
    assign ready = (state == IDLE);
`endif

    assign accept = start && ready;

    spi_clk_gen #(.HALF_DIV(HALF_DIV)) u_clk_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .sclk    (spi_sclk),
        .edge_en (edge_en),
        .tick    (tick),
        .rise    (rise),
        .fall    (fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ec       <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            spi_sclk <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            if (rise) begin
                spi_sclk <= 1'b1;
                rx_sr    <= {rx_sr[DATA_W-2:0], spi_miso};
                ec       <= ec + 1'b1;
            end

            // The last falling edge leaves MOSI on the final bit until HOLD ends.
            if (fall) begin
                spi_sclk <= 1'b0;
                ec       <= ec + 1'b1;
                if (ec != EC_FALL_LAST) begin
                    tx_sr    <= tx_sr << 1;
                    spi_mosi <= tx_sr[DATA_W-2];
                end
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= SETUP;
                        ec       <= '0;
                        tx_sr    <= tx_data;
                        spi_mosi <= tx_data[DATA_W-1];
                        spi_cs_n <= 1'b0;
                    end
                end
                SETUP: begin
                    if (tick) state <= SHIFT;
                end
                SHIFT: begin
                    if (tick && (ec == EC_LAST)) state <= HOLD;
                end
                HOLD: begin
                    if (hold_end) begin
                        rx_valid <= 1'b1;
                        rx_data  <= rx_sr;
                        // A chained word re-enters SHIFT with sclk low; its first
                        // half-period doubles as MOSI setup time for the new MSB.
                        if (accept) begin
                            state    <= SHIFT;
                            ec       <= '0;
                            tx_sr    <= tx_data;
                            spi_mosi <= tx_data[DATA_W-1];
                        end else begin
                            state    <= GAP;
                            spi_cs_n <= 1'b1;
                            spi_mosi <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (tick) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master (default build and SPI_MASTER_BURST_EN).
module tb_spi_master;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] tx_data;
    logic       ready, rx_valid, spi_sclk, spi_cs_n, spi_mosi, spi_miso;
    logic [7:0] rx_data;

    logic       start1;
    logic [7:0] tx1;
    logic       ready1, rxv1, sclk1, cs1, mosi1;
    logic [7:0] rxd1;

    int vectors     = 0;
    int miscompares = 0;

    spi_master dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
        .ready(ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    // HALF_DIV=1 instance in loopback: MISO tied to its own MOSI
    spi_master #(.DATA_W(8), .HALF_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .tx_data(tx1),
        .ready(ready1), .rx_data(rxd1), .rx_valid(rxv1),
        .spi_sclk(sclk1), .spi_cs_n(cs1), .spi_mosi(mosi1), .spi_miso(mosi1)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Slave model + monitor: shifts out 'stream' MSB-first across a cs window,
    // updates MISO after each SCLK fall, records MOSI at each SCLK rise.
    logic [15:0] stream;
    logic [15:0] cap;
    int          rises, low_len, sbit;
    logic        prev_cs, prev_sclk;
    logic [15:0] q_mosi[$];
    int          q_rises[$];
    int          q_low[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cs   = 1'b1;
            prev_sclk = 1'b0;
            spi_miso  = 1'b0;
        end else begin
            if (!spi_cs_n) begin
                if (prev_cs) begin
                    cap = 16'h0; rises = 0; low_len = 0; sbit = 0;
                end
                low_len++;
                if (!prev_sclk && spi_sclk) begin
                    cap = {cap[14:0], spi_mosi};
                    rises++;
                end
                if (prev_sclk && !spi_sclk) sbit++;
                spi_miso = (sbit < 16) ? stream[15 - sbit] : 1'b0;
            end else begin
                if (!prev_cs) begin
                    q_mosi.push_back(cap);
                    q_rises.push_back(rises);
                    q_low.push_back(low_len);
                end
                spi_miso = 1'b0;
            end
            prev_cs   = spi_cs_n;
            prev_sclk = spi_sclk;
        end
    end

    // Cycle c counts negedges after the accepting posedge (c=1 is the first cycle after acceptance).
    task automatic run_frame(input logic [7:0] tx, input int ncyc, output int vcnt,
                             output int vcyc, output logic [7:0] vdata, output int rcyc);
        vcnt = 0; vcyc = -1; vdata = 8'h00; rcyc = -1;
        @(negedge clk);
        start = 1'b1; tx_data = tx;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == 1) begin start = 1'b0; tx_data = ~tx; end
            if (rx_valid) begin vcnt++; vcyc = c; vdata = rx_data; end
            if (ready && spi_cs_n && rcyc < 0) rcyc = c;
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ready, rx_valid, spi_sclk, spi_cs_n, spi_mosi} !== 5'b10010) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy/vld/sclk/cs_n/mosi=%b want 10010",
                     {ready, rx_valid, spi_sclk, spi_cs_n, spi_mosi});
        end
        vectors++;
        if (rx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_rx_data: got %h want 00", rx_data);
        end
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rx_valid !== 1'b0 || spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || ready !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL idle_quiet: got %0d bad idle cycles want 0", bad);
        end
    endtask

    task automatic test_basic_frame();
        int vcnt, vcyc, rcyc, base;
        logic [7:0] vdata;
        stream = 16'h3C00;
        base = q_mosi.size();
        run_frame(8'hA5, 45, vcnt, vcyc, vdata, rcyc);
        vectors++;
        if (vcnt != 1) begin miscompares++; $display("FAIL basic_valid_count: got %0d want 1", vcnt); end
        vectors++;
        if (vcyc != 37) begin miscompares++; $display("FAIL basic_valid_cycle: got %0d want 37", vcyc); end
        vectors++;
        if (vdata !== 8'h3C) begin miscompares++; $display("FAIL basic_rx_data: got %h want 3c", vdata); end
        vectors++;
        if (rcyc != 39) begin miscompares++; $display("FAIL basic_ready_cycle: got %0d want 39", rcyc); end
        vectors++;
        if (q_mosi.size() != base + 1) begin
            miscompares++;
            $display("FAIL basic_cs_windows: got %0d want 1", q_mosi.size() - base);
        end else begin
            vectors++;
            if (q_mosi[base][7:0] !== 8'hA5) begin miscompares++; $display("FAIL basic_mosi: got %h want a5", q_mosi[base][7:0]); end
            vectors++;
            if (q_rises[base] != 8) begin miscompares++; $display("FAIL basic_sclk_rises: got %0d want 8", q_rises[base]); end
            vectors++;
            if (q_low[base] != 36) begin miscompares++; $display("FAIL basic_cs_low_len: got %0d want 36", q_low[base]); end
        end
    endtask

    task automatic test_loopback_div1();
        for (int k = 0; k < 2; k++) begin
            logic [7:0] v, vd;
            int vcyc, r1, r2;
            logic ps;
            v = (k == 0) ? 8'hFF : 8'h00;
            vcyc = -1; vd = 8'hXX; r1 = -1; r2 = -1; ps = 1'b0;
            @(negedge clk);
            start1 = 1'b1; tx1 = v;
            for (int c = 1; c <= 25; c++) begin
                @(negedge clk);
                if (c == 1) begin start1 = 1'b0; tx1 = ~v; end
                if (rxv1) begin vcyc = c; vd = rxd1; end
                if (!ps && sclk1) begin
                    if (r1 < 0) r1 = c;
                    else if (r2 < 0) r2 = c;
                end
                ps = sclk1;
            end
            vectors++;
            if (vd !== v) begin miscompares++; $display("FAIL loop_rx_data: got %h want %h", vd, v); end
            vectors++;
            if (vcyc != 19) begin miscompares++; $display("FAIL loop_valid_cycle: got %0d want 19", vcyc); end
            vectors++;
            if (r2 - r1 != 2) begin miscompares++; $display("FAIL loop_sclk_period: got %0d want 2", r2 - r1); end
        end
    endtask

`ifndef SPI_MASTER_BURST_EN
    task automatic test_back_to_back();
        int base, vcnt, gap;
        logic second;
        stream = 16'h0000;
        base = q_mosi.size();
        vcnt = 0; gap = 0; second = 1'b0;
        @(negedge clk);
        start = 1'b1; tx_data = 8'h81;
        for (int c = 1; c <= 90; c++) begin
            @(negedge clk);
            if (c == 10) tx_data = 8'h7E;
            if (c == 77) start = 1'b0;
            if (rx_valid) vcnt++;
            if (vcnt == 1 && !second) begin
                if (spi_cs_n) gap++;
                else second = 1'b1;
            end
        end
        vectors++;
        if (vcnt != 2) begin miscompares++; $display("FAIL b2b_valid_count: got %0d want 2", vcnt); end
        vectors++;
        if (gap < 2) begin miscompares++; $display("FAIL b2b_cs_gap: got %0d want >=2", gap); end
        vectors++;
        if (q_mosi.size() != base + 2) begin
            miscompares++;
            $display("FAIL b2b_cs_windows: got %0d want 2", q_mosi.size() - base);
        end else begin
            vectors++;
            if (q_mosi[base][7:0] !== 8'h81) begin miscompares++; $display("FAIL b2b_mosi_first: got %h want 81", q_mosi[base][7:0]); end
            vectors++;
            if (q_mosi[base+1][7:0] !== 8'h7E) begin miscompares++; $display("FAIL b2b_mosi_second: got %h want 7e", q_mosi[base+1][7:0]); end
            vectors++;
            if (q_low[base+1] != 36) begin miscompares++; $display("FAIL b2b_cs_low_len: got %0d want 36", q_low[base+1]); end
        end
    endtask
`else
    task automatic test_burst();
        int base, vcnt, acc_c;
        logic [7:0] v0, v1;
        stream = 16'hA55A;
        base = q_mosi.size();
        vcnt = 0; acc_c = -1; v0 = 8'h00; v1 = 8'h00;
        @(negedge clk);
        start = 1'b1; tx_data = 8'h12;
        for (int c = 1; c <= 90; c++) begin
            @(negedge clk);
            if (c == 1) tx_data = 8'h34;
            if (acc_c > 0 && c == acc_c + 1) start = 1'b0;
            if (start && c > 1 && ready && acc_c < 0) acc_c = c;
            if (rx_valid) begin
                if (vcnt == 0) v0 = rx_data; else v1 = rx_data;
                vcnt++;
            end
        end
        vectors++;
        if (acc_c != 36) begin miscompares++; $display("FAIL burst_ready_in_hold: got %0d want 36", acc_c); end
        vectors++;
        if (vcnt != 2) begin miscompares++; $display("FAIL burst_valid_count: got %0d want 2", vcnt); end
        vectors++;
        if (v0 !== 8'hA5 || v1 !== 8'h5A) begin miscompares++; $display("FAIL burst_rx_data: got %h %h want a5 5a", v0, v1); end
        vectors++;
        if (q_mosi.size() != base + 1) begin
            miscompares++;
            $display("FAIL burst_cs_windows: got %0d want 1", q_mosi.size() - base);
        end else begin
            vectors++;
            if (q_mosi[base] !== 16'h1234) begin miscompares++; $display("FAIL burst_mosi: got %h want 1234", q_mosi[base]); end
            vectors++;
            if (q_rises[base] != 16) begin miscompares++; $display("FAIL burst_sclk_rises: got %0d want 16", q_rises[base]); end
            vectors++;
            if (q_low[base] != 72) begin miscompares++; $display("FAIL burst_cs_low_len: got %0d want 72", q_low[base]); end
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        int rises_seen, c, vbad, vcnt, vcyc, rcyc, base;
        logic ps;
        logic [7:0] vdata;
        stream = 16'hFF00;
        rises_seen = 0; c = 0; ps = 1'b0; vbad = 0;
        @(negedge clk);
        start = 1'b1; tx_data = 8'h11;
        while (rises_seen < 4 && c < 60) begin
            @(negedge clk);
            c++;
            if (c == 1) start = 1'b0;
            if (!ps && spi_sclk) rises_seen++;
            ps = spi_sclk;
        end
        vectors++;
        if (rises_seen != 4) begin miscompares++; $display("FAIL rstmid_reach_edge: got %0d rises want 4", rises_seen); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({spi_cs_n, spi_sclk, ready, rx_valid, spi_mosi} !== 5'b10100) begin
            miscompares++;
            $display("FAIL rstmid_async: got cs_n/sclk/rdy/vld/mosi=%b want 10100",
                     {spi_cs_n, spi_sclk, ready, rx_valid, spi_mosi});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rx_valid !== 1'b0 || spi_cs_n !== 1'b1) vbad++;
        end
        vectors++;
        if (vbad != 0) begin miscompares++; $display("FAIL rstmid_aborted: got %0d bad cycles want 0", vbad); end
        stream = 16'hC300;
        base = q_mosi.size();
        run_frame(8'h5A, 45, vcnt, vcyc, vdata, rcyc);
        vectors++;
        if (vcnt != 1 || vdata !== 8'hC3) begin
            miscompares++;
            $display("FAIL rstmid_recover_rx: got cnt=%0d data=%h want cnt=1 data=c3", vcnt, vdata);
        end
        vectors++;
        if (q_mosi.size() != base + 1) begin
            miscompares++;
            $display("FAIL rstmid_recover_windows: got %0d want 1", q_mosi.size() - base);
        end else begin
            vectors++;
            if (q_mosi[base][7:0] !== 8'h5A) begin miscompares++; $display("FAIL rstmid_recover_mosi: got %h want 5a", q_mosi[base][7:0]); end
            vectors++;
            if (q_low[base] != 36) begin miscompares++; $display("FAIL rstmid_recover_cs_low: got %0d want 36", q_low[base]); end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; tx_data = 8'h00;
        start1 = 1'b0; tx1 = 8'h00; stream = 16'h0000;
        test_reset();
        test_basic_frame();
        test_loopback_div1();
`ifndef SPI_MASTER_BURST_EN
        test_back_to_back();
`else
        test_burst();
`endif
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
